change_dispenser: RTL and testbench
===================================

Name: change_dispenser

Overview:
Downstream stage of the vending controller. Takes the change amount the controller computes after a sale or refund (5-unit money granularity) and pays it out through three coin tubes (25, 10, 5). Uses a greedy FSM, one coin at a time, with a request/acknowledge handshake to the coin-ejection mechanism. Tracks per-tube inventory and reports any amount it could not pay.

Parameters:
W, 16, width of amount/residual (matches controller change width)
INV_W, 8, width of each tube inventory counter
INIT_Q25, 20, tube-25 inventory after reset/refill
INIT_Q10, 20, tube-10 inventory after reset/refill
INIT_Q5, 20, tube-5 inventory after reset/refill
ACK_TIMEOUT, 15, max cycles an eject waits for mech_ack before the tube is declared jammed

Ports:
clk  in  1  rising-edge clock
RESET_N  in  1  asynchronous active-low reset
start  in  1  one-cycle request; amount is sampled when start=1 in IDLE
amount  in  W  change to pay, in money units
refill  in  1  reload all inventories to INIT_*; honoured in IDLE only
mech_ack  in  1  mechanism confirms the requested coin has dropped
eject_25 / eject_10 / eject_5  out  1 each  one-hot coin request, held until ack or timeout
busy  out  1  high from the cycle after an accepted start until done
done  out  1  one-cycle completion pulse
short_change  out  1  residual≠0 at last completion; cleared on the next accepted start
residual  out  W  unpaid amount at last completion
inv_25 / inv_10 / inv_5  out  INV_W each  current tube inventories

Behaviour:
- Reset (RESET_N=0, async): state IDLE; all eject_* 0; busy, done, short_change 0; residual 0; inv_* = INIT_*; timeout counter 0. All outputs are registered.
- States: IDLE, SELECT, EJECT, FINISH.
- IDLE: if refill=1, reload inv_*. If start=1, latch rem=amount, clear short_change, go to SELECT. refill+start in the same cycle: reload takes effect before the first SELECT. start/refill while not IDLE: ignored.
- SELECT (1 cycle): pure greedy, no backtracking. Pick the first d in order 25, 10, 5 with rem≥d and inv_d>0.
  - Found: go to EJECT with eject_d=1 from the next cycle.
  - None found: go to FINISH.
- EJECT: hold eject_d high; increment the timeout counter each cycle.
  - mech_ack=1 at a clock edge: rem-=d, inv_d-=1, eject_d low next cycle, counter cleared, go to SELECT.
  - Counter reaches ACK_TIMEOUT with no ack: inv_d forced to 0 (tube jammed), eject_d low, counter cleared, go to SELECT. rem is unchanged.
  - mech_ack outside EJECT: ignored.
- FINISH (1 cycle): residual=rem; short_change=(rem≠0); done=1; busy=0 in this cycle; next state IDLE.
- Latency: start accepted at edge T → SELECT at T+1 → eject visible at T+2. amount=0 → done at T+2, no ejects. Each coin costs 1 SELECT cycle + ≥1 EJECT cycle.
- Non-multiple-of-5 amount: the remainder mod 5 is left in residual and short_change=1.
- Greedy shortfall is accepted behaviour. Example: amount 30, tubes 25:1 10:3 5:0 → pays 25, residual 5, short.
- Arithmetic: rem is unsigned W-bit and never underflows because of the rem≥d guard. inv_d never decrements below 0.
- Reset mid-operation: all ejects drop immediately; the payout in progress is lost; inventories return to INIT_*.

Test Plan:
1. Reset, amount=40, mech_ack 1 cycle after each eject → eject_25, eject_10, eject_5 each once in that order; done; residual=0; short_change=0; inv=19/19/19.
2. amount=0 → done exactly 2 cycles after start edge; no eject asserted; busy high 1 cycle; residual=0.
3. amount=7 → one eject_5, residual=2, short_change=1. Then a new start with amount=5 → short_change clears on accept and stays 0 at done.
4. Drain tube 25 to 0, then amount=50 → five eject_10; inv_10 drops by 5; residual=0. Repeat with refill held with start in IDLE → eject_25 ×2 instead.
5. ACK_TIMEOUT=15, never ack eject_25, amount=25 → eject_25 high 15 cycles; inv_25=0; then eject_10 ×2 and eject_5 ×1 (with ack); residual=0.
6. Assert RESET_N low while eject_10 is high → eject_10 low asynchronously; busy=0; inv_*=INIT_*. start during busy (separate run) → ignored, first payout unaffected.

Source files
------------

// File: rtl/change_dispenser.sv
// Greedy coin payout stage: pays a change amount from 25/10/5 tubes,
// one coin per mech request/ack handshake, tracking tube inventory.
module change_dispenser #(
    parameter int W           = 16,
    parameter int INV_W       = 8,
    parameter int INIT_Q25    = 20,
    parameter int INIT_Q10    = 20,
    parameter int INIT_Q5     = 20,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             RESET_N,
    input  logic             start,
    input  logic [W-1:0]     amount,
    input  logic             refill,
    input  logic             mech_ack,
    output logic             eject_25,
    output logic             eject_10,
    output logic             eject_5,
    output logic             busy,
    output logic             done,
    output logic             short_change,
    output logic [W-1:0]     residual,
    output logic [INV_W-1:0] inv_25,
    output logic [INV_W-1:0] inv_10,
    output logic [INV_W-1:0] inv_5
);

    localparam int CW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [CW-1:0]    CNT_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [W-1:0]     C25      = W'(25);
    localparam logic [W-1:0]     C10      = W'(10);
    localparam logic [W-1:0]     C5       = W'(5);
    localparam logic [INV_W-1:0] I25      = INV_W'(INIT_Q25);
    localparam logic [INV_W-1:0] I10      = INV_W'(INIT_Q10);
    localparam logic [INV_W-1:0] I5       = INV_W'(INIT_Q5);
    localparam logic [INV_W-1:0] ONE      = INV_W'(1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_FINISH
    } state_t;

    state_t           state_q;
    logic [W-1:0]     rem_q;
    logic [W-1:0]     residual_q;
    logic [CW-1:0]    cnt_q;
    logic [INV_W-1:0] inv25_q;
    logic [INV_W-1:0] inv10_q;
    logic [INV_W-1:0] inv5_q;
    logic             ej25_q;
    logic             ej10_q;
    logic             ej5_q;
    logic             busy_q;
    logic             done_q;
    logic             short_q;

    logic             pick25;
    logic             pick10;
    logic             pick5;
    logic [W-1:0]     coin_val;

    assign pick25 = (rem_q >= C25) && (inv25_q != '0);
    assign pick10 = (rem_q >= C10) && (inv10_q != '0);
    assign pick5  = (rem_q >= C5)  && (inv5_q  != '0);

    always_comb begin
        coin_val = C5;
        unique case (1'b1)
            ej25_q:  coin_val = C25;
            ej10_q:  coin_val = C10;
            default: coin_val = C5;
        endcase
    end

    always_ff @(posedge clk or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            rem_q      <= '0;
            residual_q <= '0;
            cnt_q      <= '0;
            inv25_q    <= I25;
            inv10_q    <= I10;
            inv5_q     <= I5;
            ej25_q     <= 1'b0;
            ej10_q     <= 1'b0;
            ej5_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            short_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (refill) begin
                        inv25_q <= I25;
                        inv10_q <= I10;
                        inv5_q  <= I5;
                    end
                    if (start) begin
                        rem_q   <= amount;
                        short_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    cnt_q <= '0;
                    if (pick25) begin
                        ej25_q  <= 1'b1;
                        state_q <= S_EJECT;
                    end else if (pick10) begin
                        ej10_q  <= 1'b1;
                        state_q <= S_EJECT;
                    end else if (pick5) begin
                        ej5_q   <= 1'b1;
                        state_q <= S_EJECT;
                    end else begin
                        residual_q <= rem_q;
                        short_q    <= (rem_q != '0);
                        busy_q     <= 1'b0;
                        done_q     <= 1'b1;
                        state_q    <= S_FINISH;
                    end
                end
                S_EJECT: begin
                    // ack wins over a timeout landing on the same edge
                    if (mech_ack) begin
                        rem_q <= rem_q - coin_val;
                        if (ej25_q) inv25_q <= inv25_q - ONE;
                        if (ej10_q) inv10_q <= inv10_q - ONE;
                        if (ej5_q)  inv5_q  <= inv5_q  - ONE;
                        ej25_q  <= 1'b0;
                        ej10_q  <= 1'b0;
                        ej5_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_SELECT;
                    end else if (cnt_q == CNT_LAST) begin
                        if (ej25_q) inv25_q <= '0;
                        if (ej10_q) inv10_q <= '0;
                        if (ej5_q)  inv5_q  <= '0;
                        ej25_q  <= 1'b0;
                        ej10_q  <= 1'b0;
                        ej5_q   <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= S_SELECT;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_FINISH: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign eject_25     = ej25_q;
    assign eject_10     = ej10_q;
    assign eject_5      = ej5_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign short_change = short_q;
    assign residual     = residual_q;
    assign inv_25       = inv25_q;
    assign inv_10       = inv10_q;
    assign inv_5        = inv5_q;

endmodule

// File: tb/tb_change_dispenser.sv
// Bench for change_dispenser: directed vector table, corner sequences
// and randomized payouts against a greedy arithmetic reference model.
module tb_change_dispenser;

    localparam int W      = 16;
    localparam int INV_W  = 8;
    localparam int INIT   = 20;
    localparam int TMO    = 15;
    localparam int BUDGET = 3000;

    logic             clk;
    logic             RESET_N;
    logic             start;
    logic [W-1:0]     amount;
    logic             refill;
    logic             mech_ack;
    logic             eject_25;
    logic             eject_10;
    logic             eject_5;
    logic             busy;
    logic             done;
    logic             short_change;
    logic [W-1:0]     residual;
    logic [INV_W-1:0] inv_25;
    logic [INV_W-1:0] inv_10;
    logic [INV_W-1:0] inv_5;

    change_dispenser dut (
        .clk          (clk),
        .RESET_N      (RESET_N),
        .start        (start),
        .amount       (amount),
        .refill       (refill),
        .mech_ack     (mech_ack),
        .eject_25     (eject_25),
        .eject_10     (eject_10),
        .eject_5      (eject_5),
        .busy         (busy),
        .done         (done),
        .short_change (short_change),
        .residual     (residual),
        .inv_25       (inv_25),
        .inv_10       (inv_10),
        .inv_5        (inv_5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    // reference model: tube index 0=25, 1=10, 2=5
    int m_inv[3];
    int ex_ev[$];
    int ex_res;
    int ex_lat;

    task automatic model_pay(input int amt, input bit rf,
                             input bit [2:0] jam, input int adly);
        int  vals[3];
        int  rem;
        bit  found;
        vals = '{25, 10, 5};
        rem  = amt;
        if (rf) m_inv = '{INIT, INIT, INIT};
        ex_ev.delete();
        ex_lat = 2;
        found  = 1'b1;
        while (found) begin
            found = 1'b0;
            for (int i = 0; i < 3 && !found; i++) begin
                if (rem >= vals[i] && m_inv[i] > 0) begin
                    found = 1'b1;
                    if (jam[2-i]) begin
                        m_inv[i] = 0;
                        ex_ev.push_back(i * 2 + 1);
                        ex_lat += 1 + TMO;
                    end else begin
                        rem -= vals[i];
                        m_inv[i]--;
                        ex_ev.push_back(i * 2);
                        ex_lat += 1 + adly;
                    end
                end
            end
        end
        ex_res = rem;
    endtask

    function automatic int code_of(input logic [2:0] e);
        if (e == 3'b100) return 0;
        if (e == 3'b010) return 1;
        return 2;
    endfunction

    // observed payout results
    int ev[$];
    int got_lat;
    int got_busy;

    task automatic run_pay(input int amt, input bit rf, input bit [2:0] jam,
                           input int adly, input int poke, input bit noise);
        int         k;
        int         cnt;
        bit         got;
        bit         dur_bad;
        bit         oh_bad;
        logic [2:0] ej;
        logic [2:0] prev_ej;
        ev.delete();
        @(posedge clk);
        #1;
        chk("done_pulse_end", done, 0);
        amount = W'(amt);
        refill = rf;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        refill   = 1'b0;
        k        = 0;
        cnt      = 0;
        got      = 1'b0;
        dur_bad  = 1'b0;
        oh_bad   = 1'b0;
        prev_ej  = '0;
        got_lat  = 0;
        got_busy = 0;
        while (!got && k < BUDGET) begin
            k++;
            ej = {eject_25, eject_10, eject_5};
            if (prev_ej != 0 && ej != prev_ej) begin
                if (mech_ack) begin
                    ev.push_back(code_of(prev_ej) * 2);
                    if (cnt != adly) dur_bad = 1'b1;
                end else begin
                    ev.push_back(code_of(prev_ej) * 2 + 1);
                    if (cnt != TMO) dur_bad = 1'b1;
                end
            end
            if (ej != 0) begin
                cnt = (ej == prev_ej) ? cnt + 1 : 1;
                if (!$onehot(ej)) oh_bad = 1'b1;
            end
            if (k == 1) begin
                chk("accept_busy", busy, 1);
                chk("accept_short_clr", short_change, 0);
            end
            if (busy) got_busy++;
            if (done) begin
                got     = 1'b1;
                got_lat = k;
            end
            if (ej != 0)
                mech_ack = ((jam & ej) == 0) && (cnt >= adly);
            else
                mech_ack = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            start  = 1'b0;
            refill = 1'b0;
            if (!got && k == poke) begin
                start  = 1'b1;
                refill = 1'b1;
                amount = W'($urandom_range(5, 200));
            end
            prev_ej = ej;
            if (!got) begin
                @(posedge clk);
                #1;
            end
        end
        mech_ack = 1'b0;
        start    = 1'b0;
        refill   = 1'b0;
        chk("done_seen", got, 1);
        chk("eject_duration_bad", dur_bad, 0);
        chk("eject_onehot_bad", oh_bad, 0);
    endtask

    task automatic cmp_model(input string tag);
        int bad_idx;
        bad_idx = -1;
        chk({tag, "_event_count"}, ev.size(), ex_ev.size());
        for (int i = 0; i < ev.size() && i < ex_ev.size(); i++)
            if (bad_idx < 0 && ev[i] != ex_ev[i]) bad_idx = i;
        chk({tag, "_event_order_bad_at"}, bad_idx, -1);
        chk({tag, "_residual"}, int'(residual), ex_res);
        chk({tag, "_short"}, short_change, int'(ex_res != 0));
        chk({tag, "_inv25"}, int'(inv_25), m_inv[0]);
        chk({tag, "_inv10"}, int'(inv_10), m_inv[1]);
        chk({tag, "_inv5"}, int'(inv_5), m_inv[2]);
        chk({tag, "_latency"}, got_lat, ex_lat);
        chk({tag, "_busy_cycles"}, got_busy, ex_lat - 1);
        chk({tag, "_busy_at_done"}, busy, 0);
    endtask

    typedef struct {
        int       amt;
        bit       rf;
        bit [2:0] jam;
        int       res;
        bit       sh;
        int       i25;
        int       i10;
        int       i5;
    } vec_t;

    vec_t tbl[13];

    initial begin
        tbl[0]  = '{40,   1'b0, 3'b000, 0,   1'b0, 19, 19, 19};
        tbl[1]  = '{0,    1'b0, 3'b000, 0,   1'b0, 19, 19, 19};
        tbl[2]  = '{7,    1'b0, 3'b000, 2,   1'b1, 19, 19, 18};
        tbl[3]  = '{5,    1'b0, 3'b000, 0,   1'b0, 19, 19, 17};
        tbl[4]  = '{25,   1'b0, 3'b100, 0,   1'b0, 0,  17, 16};
        tbl[5]  = '{50,   1'b0, 3'b000, 0,   1'b0, 0,  12, 16};
        tbl[6]  = '{50,   1'b1, 3'b000, 0,   1'b0, 18, 20, 20};
        tbl[7]  = '{3,    1'b0, 3'b000, 3,   1'b1, 18, 20, 20};
        tbl[8]  = '{1000, 1'b0, 3'b000, 250, 1'b1, 0,  0,  0};
        tbl[9]  = '{0,    1'b1, 3'b000, 0,   1'b0, 20, 20, 20};
        tbl[10] = '{20,   1'b0, 3'b010, 0,   1'b0, 20, 0,  16};
        tbl[11] = '{30,   1'b0, 3'b001, 5,   1'b1, 19, 0,  0};
        tbl[12] = '{30,   1'b0, 3'b000, 5,   1'b1, 18, 0,  0};

        RESET_N  = 1'b0;
        start    = 1'b0;
        amount   = '0;
        refill   = 1'b0;
        mech_ack = 1'b0;
        m_inv    = '{INIT, INIT, INIT};
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ejects", int'({eject_25, eject_10, eject_5}), 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_short", short_change, 0);
        chk("rst_residual", int'(residual), 0);
        chk("rst_inv25", int'(inv_25), INIT);
        chk("rst_inv10", int'(inv_10), INIT);
        chk("rst_inv5", int'(inv_5), INIT);
        RESET_N = 1'b1;

        foreach (tbl[i]) begin
            model_pay(tbl[i].amt, tbl[i].rf, tbl[i].jam, 1);
            run_pay(tbl[i].amt, tbl[i].rf, tbl[i].jam, 1, 0, 1'b0);
            cmp_model($sformatf("row%0d", i));
            chk($sformatf("row%0d_tbl_res", i), int'(residual), tbl[i].res);
            chk($sformatf("row%0d_tbl_short", i), short_change, tbl[i].sh);
            chk($sformatf("row%0d_tbl_inv25", i), int'(inv_25), tbl[i].i25);
            chk($sformatf("row%0d_tbl_inv10", i), int'(inv_10), tbl[i].i10);
            chk($sformatf("row%0d_tbl_inv5", i), int'(inv_5), tbl[i].i5);
        end

        // start and refill pulsed mid-payout must not disturb it
        model_pay(15, 1'b1, 3'b000, 2);
        run_pay(15, 1'b1, 3'b000, 2, 0, 1'b0);
        cmp_model("prep");
        model_pay(40, 1'b0, 3'b000, 1);
        run_pay(40, 1'b0, 3'b000, 1, 3, 1'b0);
        cmp_model("poke");

        // async reset while eject_10 is held
        @(posedge clk);
        #1;
        amount = W'(10);
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int i = 0; i < 8 && !eject_10; i++) begin
            @(posedge clk);
            #1;
        end
        chk("mid_eject10_seen", eject_10, 1);
        #2;
        RESET_N = 1'b0;
        #1;
        chk("mid_rst_eject10", eject_10, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_inv25", int'(inv_25), INIT);
        chk("mid_rst_inv10", int'(inv_10), INIT);
        chk("mid_rst_inv5", int'(inv_5), INIT);
        m_inv = '{INIT, INIT, INIT};
        @(posedge clk);
        #1;
        RESET_N = 1'b1;

        for (int n = 0; n < 40; n++) begin
            int       amt;
            bit       rf;
            bit [2:0] jam;
            int       adly;
            int       poke;
            if ($urandom_range(0, 4) == 0)
                amt = $urandom_range(0, 400);
            else
                amt = 5 * $urandom_range(0, 60);
            rf   = ($urandom_range(0, 3) == 0);
            jam  = {($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 9) == 0)};
            adly = $urandom_range(1, 3);
            poke = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 20) : 0;
            model_pay(amt, rf, jam, adly);
            run_pay(amt, rf, jam, adly, poke, 1'b1);
            cmp_model($sformatf("rnd%0d", n));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
